// File: rtl/seg_scan_pkg.sv
// Shared types and frame layout for the 7-segment/keypad scan master.
// The frame byte carries the keypad column, the digit select and the hex value.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    localparam int FRAME_BITS = 8;

    localparam int COL_MSB = 7;
    localparam int COL_LSB = 6;
    localparam int SEL_MSB = 5;
    localparam int SEL_LSB = 4;
    localparam int VAL_MSB = 3;
    localparam int VAL_LSB = 0;

    // Slot bits [1:0] pick the keypad column, bits [3:2] pick the digit.
    function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [3:0] slot,
                                                         input logic [3:0] value);
        logic [FRAME_BITS-1:0] frame;
        frame                   = '0;
        frame[COL_MSB:COL_LSB]  = slot[1:0];
        frame[SEL_MSB:SEL_LSB]  = slot[3:2];
        frame[VAL_MSB:VAL_LSB]  = value;
        return frame;
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// SPI byte shifter: SCK divider, MSB-first shift register and bit counter.
// done_o is high in the cycle whose clock edge produces the last SCK fall.
module spi_frame_tx
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV = 4
)
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] byte_i,
    output logic                  sck_o,
    output logic                  mosi_o,
    output logic                  done_o
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int                BIT_W    = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0]      divCnt_q;
    logic [BIT_W-1:0]      bitCnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  sck_q;
    logic                  active_q;
    logic                  divWrap;

    assign divWrap = (divCnt_q == DIV_LAST);
    assign done_o  = active_q && sck_q && divWrap && (bitCnt_q == BIT_LAST);
    assign sck_o   = sck_q;
    assign mosi_o  = shift_q[FRAME_BITS-1];

    // Each SCK phase lasts CLK_DIV cycles; the next bit moves onto MOSI on the fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divCnt_q <= '0;
            bitCnt_q <= '0;
            shift_q  <= '0;
            sck_q    <= 1'b0;
            active_q <= 1'b0;
        end else if (start_i) begin
            divCnt_q <= '0;
            bitCnt_q <= '0;
            shift_q  <= byte_i;
            sck_q    <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (divWrap) begin
                divCnt_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q    <= 1'b0;
                    shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
                    bitCnt_q <= bitCnt_q + 1'b1;
                    if (bitCnt_q == BIT_LAST) begin
                        active_q <= 1'b0;
                    end
                end
            end else begin
                divCnt_q <= divCnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan master: cycles 16 slots, each sending one display/keypad frame,
// and debounces the keypad return over two consecutive complete scans.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int HOLD_CYCLES = 1024
)
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_addr_i,
    input  logic [3:0]  wr_data_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        en_o,
    input  logic        miso_i,
    output logic [15:0] key_map_o,
    output logic        key_valid_o,
    output logic        key_event_o,
    output logic [3:0]  key_code_o,
    output logic        scan_done_o
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            slot_q;
    logic [3:0]            digit_q [4];
    logic                  en_q;
    logic [HOLD_W-1:0]     holdCnt_q;
    logic [15:0]           raw_q;
    logic [15:0]           prevRaw_q;
    logic [15:0]           keyMap_q;
    logic                  keyValid_q;
    logic                  keyEvent_q;
    logic [3:0]            keyCode_q;
    logic                  scanDone_q;

    logic                  txStart;
    logic                  txDone;
    logic                  holdLast;
    logic [3:0]            captSlot;
    logic [FRAME_BITS-1:0] captByte;
    logic [15:0]           rawFull;
    logic [15:0]           newKeys;
    logic [3:0]            lowestNew;

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (txStart),
        .byte_i  (captByte),
        .sck_o   (sck_o),
        .mosi_o  (mosi_o),
        .done_o  (txDone)
    );

    assign holdLast = (state_q == HOLD) && (holdCnt_q == HOLD_LAST);

    // Back-to-back frames capture during the last HOLD cycle, so they use the next slot.
    assign captSlot = (state_q == HOLD) ? slot_q + 4'd1 : slot_q;
    assign captByte = buildFrame(captSlot, digit_q[captSlot[3:2]]);

    always_comb begin
        rawFull          = raw_q;
        rawFull[slot_q]  = ~miso_i;
        newKeys          = rawFull & ~keyMap_q;
        lowestNew        = '0;
        for (int i = 15; i >= 0; i--) begin
            if (newKeys[i]) begin
                lowestNew = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        txStart = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i) begin
                    txStart = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (txDone) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (holdLast) begin
                    if (run_i) begin
                        txStart = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            en_q      <= 1'b1;
            holdCnt_q <= '0;
            raw_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (wr_en_i) begin
                digit_q[wr_addr_i] <= wr_data_i;
            end
            if (txDone) begin
                en_q <= 1'b0;
            end else if (holdLast) begin
                en_q <= 1'b1;
            end
            if ((state_q == HOLD) && !holdLast) begin
                holdCnt_q <= holdCnt_q + 1'b1;
            end else begin
                holdCnt_q <= '0;
            end
            // Stopping abandons the partial scan so the next start is a clean slot 0.
            if (holdLast) begin
                if (run_i) begin
                    slot_q <= slot_q + 4'd1;
                    raw_q  <= rawFull;
                end else begin
                    slot_q <= '0;
                    raw_q  <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prevRaw_q  <= '0;
            keyMap_q   <= '0;
            keyValid_q <= 1'b0;
            keyEvent_q <= 1'b0;
            keyCode_q  <= '0;
            scanDone_q <= 1'b0;
        end else begin
            keyEvent_q <= 1'b0;
            scanDone_q <= 1'b0;
            if (holdLast && (slot_q == 4'hF)) begin
                scanDone_q <= 1'b1;
                prevRaw_q  <= rawFull;
                if (rawFull == prevRaw_q) begin
                    keyMap_q   <= rawFull;
                    keyValid_q <= 1'b1;
                    if (|newKeys) begin
                        keyEvent_q <= 1'b1;
                        keyCode_q  <= lowestNew;
                    end
                end
            end
        end
    end

    assign en_o        = en_q;
    assign key_map_o   = keyMap_q;
    assign key_valid_o = keyValid_q;
    assign key_event_o = keyEvent_q;
    assign key_code_o  = keyCode_q;
    assign scan_done_o = scanDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a board model latches frames and answers the keypad,
// and a scan-level key model predicts key_map, key_valid, key_event and key_code.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV     = 1;
    localparam int HOLD_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        sck;
    logic        mosi;
    logic        en;
    logic        miso;
    logic [15:0] key_map;
    logic        key_valid;
    logic        key_event;
    logic [3:0]  key_code;
    logic        scan_done;

    int assertCount = 0;
    int failCount   = 0;

    seg_scan_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .run_i       (run),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .sck_o       (sck),
        .mosi_o      (mosi),
        .en_o        (en),
        .miso_i      (miso),
        .key_map_o   (key_map),
        .key_valid_o (key_valid),
        .key_event_o (key_event),
        .key_code_o  (key_code),
        .scan_done_o (scan_done)
    );

    always #5 clk = ~clk;

    // Board model: shift on SCK rise, latch on EN fall, pull MISO low for a pressed key.
    logic [7:0]  boardShift = '0;
    logic [7:0]  latched    = '0;
    logic [15:0] keysNow    = '0;
    logic [7:0]  byteQ [$];
    int          lowQ [$];
    int          lowCnt       = 0;
    int          sckRises     = 0;
    int          sckRiseInEn0 = 0;
    int          enFalls      = 0;
    int          enRises      = 0;
    int          evSeen       = 0;
    int          doneSeen     = 0;

    assign miso = ~keysNow[{latched[5:4], latched[7:6]}];

    always @(posedge sck) begin
        boardShift = {boardShift[6:0], mosi};
        sckRises++;
        if (en === 1'b0) sckRiseInEn0++;
    end

    always @(negedge en) begin
        latched = boardShift;
        byteQ.push_back(boardShift);
        enFalls++;
    end

    always @(posedge en) begin
        lowQ.push_back(lowCnt);
        enRises++;
    end

    always @(negedge clk) begin
        if (en === 1'b0) lowCnt++;
        else lowCnt = 0;
        if (key_event === 1'b1) evSeen++;
        if (scan_done === 1'b1) doneSeen++;
    end

    // Scan-level key model.
    logic [3:0]  digitModel [4];
    logic [15:0] mPrev  = '0;
    logic [15:0] mMap   = '0;
    logic        mValid = 1'b0;
    logic [3:0]  mCode  = '0;
    int          expEvents = 0;
    int          expScans  = 0;
    int          byteRd    = 0;
    int          lowRd     = 0;

    function automatic logic [7:0] expByte(input int s);
        logic [3:0] sv;
        sv = 4'(s);
        return {sv[1:0], sv[3:2], digitModel[sv[3:2]]};
    endfunction

    task automatic modelScan(input logic [15:0] cur, output logic ev);
        logic [15:0] fresh;
        ev = 1'b0;
        if (cur == mPrev) begin
            fresh  = cur & ~mMap;
            mValid = 1'b1;
            if (fresh != 16'h0) begin
                ev = 1'b1;
                expEvents++;
                for (int i = 15; i >= 0; i--) begin
                    if (fresh[i]) mCode = 4'(i);
                end
            end
            mMap = cur;
        end
        mPrev = cur;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [3:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        digitModel[addr] = data;
    endtask

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_sck"},       32'(sck),       32'h0);
        checkOutput({phase, "_mosi"},      32'(mosi),      32'h0);
        checkOutput({phase, "_en"},        32'(en),        32'h1);
        checkOutput({phase, "_key_map"},   32'(key_map),   32'h0);
        checkOutput({phase, "_key_valid"}, 32'(key_valid), 32'h0);
        checkOutput({phase, "_key_event"}, 32'(key_event), 32'h0);
        checkOutput({phase, "_key_code"},  32'(key_code),  32'h0);
        checkOutput({phase, "_scan_done"}, 32'(scan_done), 32'h0);
    endtask

    task automatic checkFrames(input int count, input string tag);
        checkOutput({tag, "_frames"}, 32'(byteQ.size() - byteRd), 32'(count));
        for (int i = 0; i < count; i++) begin
            if (byteRd + i < byteQ.size())
                checkOutput($sformatf("%s_byte%0d", tag, i), 32'(byteQ[byteRd + i]), 32'(expByte(i)));
        end
        byteRd = byteQ.size();
        checkOutput({tag, "_en_lows"}, 32'(lowQ.size() - lowRd), 32'(count));
        for (int i = lowRd; i < lowQ.size(); i++) begin
            checkOutput($sformatf("%s_en_low%0d", tag, i - lowRd), 32'(lowQ[i]), 32'(HOLD_CYCLES));
        end
        lowRd = lowQ.size();
    endtask

    task automatic runScan(input logic [15:0] keys, input string tag);
        logic got;
        logic ev;
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (scan_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_scan_done_seen"}, 32'(got), 32'h1);
        expScans++;
        modelScan(keys, ev);
        checkOutput({tag, "_key_event"}, 32'(key_event), 32'(ev));
        checkOutput({tag, "_key_map"},   32'(key_map),   32'(mMap));
        checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'(mValid));
        checkOutput({tag, "_key_code"},  32'(key_code),  32'(mCode));
        checkFrames(16, tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_event_width"}, 32'(key_event), 32'h0);
        checkOutput({tag, "_done_width"},  32'(scan_done), 32'h0);
    endtask

    task automatic waitEnRises(input int n, input string tag);
        int  base;
        logic got;
        base = enRises;
        got  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (enRises - base >= n) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(got), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] plan [$];
        logic [15:0] prevKeys;
        int          sckBase;
        int          enBase;
        int          doneBase;
        logic        gotLow;

        rst_n   = 1'b0;
        run     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 4; i++) digitModel[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        byteRd = byteQ.size();
        lowRd  = lowQ.size();

        // Idle with run low: nothing should move.
        sckBase = sckRises;
        enBase  = enFalls;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("idle_sck_rises", 32'(sckRises - sckBase), 32'h0);
        checkOutput("idle_en_falls",  32'(enFalls - enBase),   32'h0);
        checkOutput("idle_en",        32'(en),                 32'h1);
        checkOutput("idle_sck",       32'(sck),                32'h0);

        applyStimulus(2'd0, 4'h1);
        applyStimulus(2'd1, 4'h2);
        applyStimulus(2'd2, 4'h3);
        applyStimulus(2'd3, 4'h4);
        doneBase = doneSeen;

        // Quiet, key 9 press, hold, one-scan bounce, release, then keys 3+12 together.
        plan = '{16'h0000, 16'h0200, 16'h0200, 16'h0200, 16'h0220, 16'h0200,
                 16'h0000, 16'h0000, 16'h1008, 16'h1008};
        prevKeys = 16'h1008;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) prevKeys = 16'($urandom) & 16'($urandom);
            plan.push_back(prevKeys);
        end

        keysNow = plan[0];
        run     = 1'b1;
        for (int n = 0; n < plan.size(); n++) begin
            keysNow = plan[n];
            runScan(plan[n], $sformatf("scan%0d", n));
        end

        // Drop run in the middle of SHIFT for slot 5; that frame must still finish.
        waitEnRises(5, "reach_slot5");
        repeat (3) @(posedge clk);
        #1;
        run = 1'b0;
        waitEnRises(1, "slot5_frame_end");
        sckBase = sckRises;
        enBase  = enFalls;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("stop_en",        32'(en),                 32'h1);
        checkOutput("stop_sck",       32'(sck),                32'h0);
        checkOutput("stop_sck_rises", 32'(sckRises - sckBase), 32'h0);
        checkOutput("stop_en_falls",  32'(enFalls - enBase),   32'h0);
        checkFrames(6, "partial");

        applyStimulus(2'd0, 4'hA);
        applyStimulus(2'd1, 4'($urandom));
        applyStimulus(2'd2, 4'($urandom));
        applyStimulus(2'd3, 4'($urandom));

        plan.delete();
        prevKeys = keysNow;
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 0) prevKeys = 16'($urandom) & 16'($urandom);
            plan.push_back(prevKeys);
        end
        plan.push_back(16'h8001);
        plan.push_back(16'h8001);

        keysNow = plan[0];
        run     = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (byteQ.size() > byteRd) break;
        end
        checkOutput("restart_first_byte", (byteQ.size() > byteRd) ? 32'(byteQ[byteRd]) : 32'hFFFF_FFFF, 32'h0A);
        for (int n = 0; n < plan.size(); n++) begin
            keysNow = plan[n];
            runScan(plan[n], $sformatf("rescan%0d", n));
        end

        checkOutput("total_key_events", 32'(evSeen),             32'(expEvents));
        checkOutput("total_scan_done",  32'(doneSeen - doneBase), 32'(expScans));
        checkOutput("sck_rise_in_hold", 32'(sckRiseInEn0),       32'h0);

        // Asynchronous reset in the middle of a HOLD period.
        gotLow = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (en === 1'b0) begin
                gotLow = 1'b1;
                break;
            end
        end
        checkOutput("reach_hold", 32'(gotLow), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues("midrun_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
